// File: rtl/image_proc_pkg.sv
// image_proc_pkg: shared FSM encoding, default frame geometry and the BMP row-flip address helper.
package image_proc_pkg;
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;

    localparam int DEF_WIDTH       = 10;
    localparam int DEF_HEIGHT      = 5;
    localparam int DEF_FRAME_BYTES = DEF_WIDTH * DEF_HEIGHT * 3;

    // BMP stores the bottom row first, so row r lands at row slot HEIGHT-1-r.
    function automatic int unsigned flip_addr(input int unsigned row, input int unsigned col,
                                              input int unsigned width, input int unsigned height);
        return width * 3 * (height - 1 - row) + 3 * col;
    endfunction
endpackage

// File: rtl/image_frame_buffer.sv
// image_frame_buffer: byte frame store with a 6-byte pixel-pair write port and a 1-byte async read port.
module image_frame_buffer #(
    parameter int DEPTH = 150,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [47:0]   wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            for (int i = 0; i < 6; i++)
                mem[wr_addr + AW'(i)] <= wr_data[47 - 8*i -: 8];
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/image_write.sv
// image_write: captures a two-pixel-per-clock RGB888 stream into a bottom-up BMP byte buffer and drains it.
// Optional IMAGE_WRITE_CHECKSUM_EN builds a 16-bit wrapping byte sum of the captured frame.
module image_write
    import image_proc_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int HEIGHT      = DEF_HEIGHT,
    parameter int FRAME_BYTES = WIDTH * HEIGHT * 3
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        VSYNC,
    input  logic        HSYNC,
    input  logic [7:0]  DATA_R0,
    input  logic [7:0]  DATA_G0,
    input  logic [7:0]  DATA_B0,
    input  logic [7:0]  DATA_R1,
    input  logic [7:0]  DATA_G1,
    input  logic [7:0]  DATA_B1,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        frame_done,
    output logic        frame_err,
    output logic        busy,
    output logic [15:0] checksum
);
    localparam int CW    = $clog2(FRAME_BYTES + 1);
    localparam int RW    = $clog2(HEIGHT + 1);
    localparam int XW    = $clog2(WIDTH + 1);
    localparam int PAIRS = WIDTH * HEIGHT / 2;

    logic [1:0]    state;
    logic [RW-1:0] row;
    logic [XW-1:0] col;
    logic [CW-1:0] pair_cnt;
    logic [CW-1:0] rd_ptr;
    logic [CW-1:0] wr_base;
    logic [7:0]    rd_data;
    logic          abort;
    logic          we;
    logic          row_end;
    logic          last_byte;

    assign abort     = state == ST_CAPTURE && VSYNC && pair_cnt != '0;
    assign we        = state == ST_CAPTURE && HSYNC && !abort;
    assign row_end   = col == XW'(WIDTH - 2);
    assign last_byte = rd_ptr == CW'(FRAME_BYTES - 1);
    assign wr_base   = CW'(flip_addr(32'(row), 32'(col), WIDTH, HEIGHT));

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state      <= ST_IDLE;
            row        <= '0;
            col        <= '0;
            pair_cnt   <= '0;
            rd_ptr     <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            if (state == ST_IDLE) begin
                if (VSYNC)
                    state <= ST_CAPTURE;
            end else if (state == ST_CAPTURE) begin
                if (abort) begin
                    frame_err <= 1'b1;
                    row       <= '0;
                    col       <= '0;
                    pair_cnt  <= '0;
                end else if (HSYNC) begin
                    col      <= row_end ? '0 : col + XW'(2);
                    row      <= row_end ? row + RW'(1) : row;
                    pair_cnt <= pair_cnt + CW'(1);
                    if (pair_cnt == CW'(PAIRS - 1)) begin
                        frame_done <= 1'b1;
                        state      <= ST_DRAIN;
                        row        <= '0;
                        col        <= '0;
                        pair_cnt   <= '0;
                    end
                end
            end else if (state == ST_DRAIN) begin
                if (out_ready) begin
                    rd_ptr <= last_byte ? '0 : rd_ptr + CW'(1);
                    state  <= last_byte ? ST_IDLE : ST_DRAIN;
                end
            end else begin
                state <= ST_IDLE;
            end
        end
    end

    image_frame_buffer #(.DEPTH(FRAME_BYTES), .AW(CW)) u_buf (
        .clk     (HCLK),
        .we      (we),
        .wr_addr (wr_base),
        .wr_data ({DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1}),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    assign out_valid = state == ST_DRAIN;
    assign out_data  = out_valid ? rd_data : '0;
    assign out_last  = out_valid && last_byte;
    assign busy      = state != ST_IDLE;

`ifdef IMAGE_WRITE_CHECKSUM_EN
    logic [15:0] sum;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET)
            sum <= '0;
        else if ((state == ST_IDLE && VSYNC) || abort)
            sum <= '0;
        else if (we)
            sum <= sum + 16'(DATA_R0) + 16'(DATA_G0) + 16'(DATA_B0)
                       + 16'(DATA_R1) + 16'(DATA_G1) + 16'(DATA_B1);
    end

    assign checksum = sum;
`else
    assign checksum = '0;
`endif
endmodule

// File: tb/tb_image_write.sv
// tb_image_write: directed frames into image_write; a negedge monitor checks drained bytes against a queue.
module tb_image_write;
    localparam int W  = 10;
    localparam int H  = 5;
    localparam int FB = W * H * 3;
    localparam int NP = W * H / 2;
`ifdef IMAGE_WRITE_CHECKSUM_EN
    localparam bit CS_EN = 1'b1;
`else
    localparam bit CS_EN = 1'b0;
`endif

    logic HCLK = 1'b0, HRESET = 1'b1, VSYNC = 1'b0, HSYNC = 1'b0;
    logic [7:0] DATA_R0 = '0, DATA_G0 = '0, DATA_B0 = '0;
    logic [7:0] DATA_R1 = '0, DATA_G1 = '0, DATA_B1 = '0;
    logic [7:0]  out_data;
    logic        out_valid, out_last, frame_done, frame_err, busy;
    logic        out_ready = 1'b1;
    logic [15:0] checksum;

    int n_cmp = 0, n_bad = 0;
    logic [8:0] exp_q[$];
    logic [7:0] mdl[FB];
    logic [7:0] got[FB];
    int acc_cnt = 0, last_cnt = 0, done_cnt = 0, err_cnt = 0, cyc = 0;
    logic [15:0] cs_mdl = '0, cs_at_done = '0;
    bit bp_mode = 1'b0;
    logic [3:0] pat = 4'b1001;

    image_write dut (
        .HCLK(HCLK), .HRESET(HRESET), .VSYNC(VSYNC), .HSYNC(HSYNC),
        .DATA_R0(DATA_R0), .DATA_G0(DATA_G0), .DATA_B0(DATA_B0),
        .DATA_R1(DATA_R1), .DATA_G1(DATA_G1), .DATA_B1(DATA_B1),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .frame_done(frame_done), .frame_err(frame_err), .busy(busy), .checksum(checksum)
    );

    always #5 HCLK = ~HCLK;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    always @(posedge HCLK) begin
        cyc = cyc + 1;
        #1 out_ready = bp_mode ? pat[cyc % 4] : 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    logic pv = 1'b0, pr = 1'b0, pl = 1'b0;
    logic [7:0] pd = '0;
    always @(negedge HCLK) begin
        logic [8:0] e;
        if (HRESET) begin
            exp_q.delete();
            acc_cnt = 0;
            pv = 1'b0;
        end else begin
            if (frame_done) begin
                done_cnt++;
                cs_at_done = checksum;
                chk("valid_with_done", 32'(out_valid), 32'd1);
            end
            if (frame_err)
                err_cnt++;
            if (pv && !pr && out_valid) begin
                chk("stall_data", 32'(out_data), 32'(pd));
                chk("stall_last", 32'(out_last), 32'(pl));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_byte: got 0x%0h with empty scoreboard", out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("byte%0d", acc_cnt), 32'(out_data), 32'(e[7:0]));
                    chk($sformatf("last%0d", acc_cnt), 32'(out_last), 32'(e[8]));
                end
                if (acc_cnt < FB)
                    got[acc_cnt] = out_data;
                if (out_last) begin
                    last_cnt++;
                    acc_cnt = 0;
                end else begin
                    acc_cnt++;
                end
            end
            pv = out_valid;
            pr = out_ready;
            pd = out_data;
            pl = out_last;
        end
    end

    task automatic tick;
        @(posedge HCLK);
        #1;
    endtask

    task automatic start_frame;
        VSYNC = 1'b1;
        tick;
        tick;
        VSYNC = 1'b0;
        cs_mdl = '0;
    endtask

    // Pair k covers row k/(W/2); BMP places row r at byte W*3*(H-1-r).
    task automatic send_pairs(input int n, input logic [7:0] seed, input bit ff, input bit gaps);
        for (int k = 0; k < n; k++) begin
            logic [7:0] b[6];
            int base;
            if (gaps && k % 3 == 1) begin
                HSYNC = 1'b0;
                tick;
            end
            base = W * 3 * (H - 1 - k / (W / 2)) + 6 * (k % (W / 2));
            for (int i = 0; i < 6; i++) begin
                b[i] = ff ? 8'hFF : seed + 8'(6 * k + i);
                mdl[base + i] = b[i];
                cs_mdl = cs_mdl + 16'(b[i]);
            end
            {DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1} = {b[0], b[1], b[2], b[3], b[4], b[5]};
            HSYNC = 1'b1;
            if (k == NP - 1)
                for (int j = 0; j < FB; j++)
                    exp_q.push_back({j == FB - 1, mdl[j]});
            tick;
        end
        HSYNC = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while (busy && t < 3000) begin
            tick;
            t++;
        end
        chk(name, 32'(busy), 32'd0);
    endtask

    initial begin
        int d0, l0, e0, t;
        repeat (3) @(posedge HCLK);
        #1;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(frame_done), 0);
        chk("rst_err", 32'(frame_err), 0);
        chk("rst_last", 32'(out_last), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_checksum", 32'(checksum), 0);
        HRESET = 1'b0;
        tick;

        d0 = done_cnt; l0 = last_cnt;
        start_frame;
        send_pairs(NP, 8'h11, 1'b0, 1'b1);
        wait_idle("f1_drain_timeout");
        chk("f1_done_pulses", 32'(done_cnt - d0), 1);
        chk("f1_last_count", 32'(last_cnt - l0), 1);
        for (int i = 0; i < 6; i++)
            chk($sformatf("rowflip_%0d", 120 + i), 32'(got[120 + i]), 32'h11 + 32'(i));
        chk("f1_byte0", 32'(got[0]), 32'h89);
        chk("f1_byte149", 32'(got[149]), 32'h2E);
        chk("f1_checksum_done", 32'(cs_at_done), CS_EN ? 32'(cs_mdl) : 32'd0);
        chk("f1_checksum_hold", 32'(checksum), CS_EN ? 32'(cs_mdl) : 32'd0);

        bp_mode = 1'b1;
        d0 = done_cnt; l0 = last_cnt;
        start_frame;
        send_pairs(NP, 8'h40, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            HSYNC = 1'b1;
            VSYNC = (i == 3);
            {DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1} = {6{8'hEE}};
            tick;
        end
        HSYNC = 1'b0;
        VSYNC = 1'b0;
        wait_idle("f2_drain_timeout");
        bp_mode = 1'b0;
        chk("f2_done_pulses", 32'(done_cnt - d0), 1);
        chk("f2_last_count", 32'(last_cnt - l0), 1);
        chk("f2_checksum", 32'(checksum), CS_EN ? 32'(cs_mdl) : 32'd0);

        d0 = done_cnt; l0 = last_cnt; e0 = err_cnt;
        start_frame;
        send_pairs(7, 8'h20, 1'b0, 1'b0);
        VSYNC = 1'b1;
        tick;
        VSYNC = 1'b0;
        cs_mdl = '0;
        tick;
        tick;
        chk("abort_err_pulse", 32'(err_cnt - e0), 1);
        chk("abort_busy", 32'(busy), 1);
        send_pairs(NP, 8'h30, 1'b0, 1'b1);
        wait_idle("f3_drain_timeout");
        chk("f3_done_pulses", 32'(done_cnt - d0), 1);
        chk("f3_last_count", 32'(last_cnt - l0), 1);
        chk("f3_byte0", 32'(got[0]), 32'hA8);
        chk("f3_checksum", 32'(cs_at_done), CS_EN ? 32'(cs_mdl) : 32'd0);

        start_frame;
        send_pairs(NP, 8'h50, 1'b0, 1'b0);
        t = 0;
        while (acc_cnt != 50 && t < 1000) begin
            @(posedge HCLK);
            #2;
            t++;
        end
        chk("reach_byte50", 32'(acc_cnt), 50);
        chk("pre_reset_byte50", 32'(out_data), 32'(mdl[50]));
        HRESET = 1'b1;
        #1;
        chk("midrst_valid", 32'(out_valid), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_data", 32'(out_data), 0);
        chk("midrst_checksum", 32'(checksum), 0);
        tick;
        tick;
        HRESET = 1'b0;
        tick;
        d0 = done_cnt; l0 = last_cnt;
        start_frame;
        send_pairs(NP, 8'h60, 1'b0, 1'b1);
        wait_idle("f5_drain_timeout");
        chk("f5_done_pulses", 32'(done_cnt - d0), 1);
        chk("f5_last_count", 32'(last_cnt - l0), 1);
        chk("f5_byte0", 32'(got[0]), 32'hD8);

        start_frame;
        send_pairs(NP, 8'h00, 1'b1, 1'b0);
        wait_idle("ff_drain_timeout");
        chk("ff_checksum_done", 32'(cs_at_done), CS_EN ? 32'h956A : 32'd0);
        chk("ff_checksum_hold", 32'(checksum), CS_EN ? 32'h956A : 32'd0);

        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        chk("total_err_pulses", 32'(err_cnt), 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
